wb_arbiter: RTL

//  Arbitrates the single general-register-file write-back port between the execution units:

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/wb_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Holds the default widths and requester count, plus the requester index map.
// Requester order: INTE/LOGIC, SHIFT, LOAD (LOAD is always the highest index).
package wb_arb_pkg;

    localparam int WB_N_REQ  = 3;
    localparam int WB_W_REG  = 4;
    localparam int WB_W_DATA = 32;

    localparam int REQ_INTE  = 0;
    localparam int REQ_SHIFT = 1;
    localparam int REQ_LD    = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant picker: first valid request at or above ptr, wrapping modulo N.
// Latency: purely combinational, no state.
// Backpressure: none; a request is simply not granted while another wins.
// Ports: req (request vector), ptr (scan start), gnt (one-hot grant),
//        idx (index of the grant), any (a grant was made).
module rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N     = WB_N_REQ,
    parameter int W_IDX = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [W_IDX-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [W_IDX-1:0] idx,
    output logic             any
);

    int best;
    int best_d;
    int d;

    // Each request's distance from ptr in scan order; the nearest valid one wins.
    // Indexing stays constant per loop iteration so no variable bit-selects are needed.
    always_comb begin
        best   = 0;
        best_d = N;
        d      = 0;
        for (int i = 0; i < N; i++) begin
            d = (i + 2 * N - int'(ptr)) % N;
            if (req[i] && (d < best_d)) begin
                best_d = d;
                best   = i;
            end
        end
        any = (best_d < N);
        idx = best[W_IDX-1:0];
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = any && (best == i);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates the single register-file write-back port between the execution units.
// Latency: grant is combinational; the winning write appears on wb_* one cycle later.
// Backpressure: losers see req_ready_o=0 and hold; busy_o flags any valid loser.
// Ports: clk, rst (sync, active-high); req_valid_i/req_addr_i/req_data_i and
//        req_ready_o per requester; wb_o/wb_r_o/wb_data_o to the register file; busy_o.
// Build option: WB_ARB_LOAD_PRIO_EN makes LOAD (highest index) win whenever valid.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_REQ  = WB_N_REQ,
    parameter int W_REG  = WB_W_REG,
    parameter int W_DATA = WB_W_DATA
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ*W_REG-1:0]    req_addr_i,
    input  logic [N_REQ*W_DATA-1:0]   req_data_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic                      wb_o,
    output logic [W_REG-1:0]          wb_r_o,
    output logic [W_DATA-1:0]         wb_data_o,
    output logic                      busy_o
);

    localparam int W_IDX = $clog2(N_REQ);

    logic [W_IDX-1:0]  rr_ptr;
    logic [W_IDX-1:0]  rr_idx;
    logic [W_IDX-1:0]  win_idx;
    logic [W_IDX-1:0]  ptr_nxt;
    logic [N_REQ-1:0]  rr_req;
    logic [N_REQ-1:0]  rr_gnt;
    logic [N_REQ-1:0]  gnt;
    logic              rr_any;
    logic              win_any;
    logic              ptr_upd;
    logic [W_REG-1:0]  sel_addr;
    logic [W_DATA-1:0] sel_data;

`ifdef WB_ARB_LOAD_PRIO_EN
    localparam int LD = N_REQ - 1;
    // LOAD is removed from the rotation; the others share the round-robin pointer.
    assign rr_req = req_valid_i & ~(N_REQ'(1) << LD);
`else
    assign rr_req = req_valid_i;
`endif

    rr_arbiter #(
        .N     (N_REQ),
        .W_IDX (W_IDX)
    ) u_rr (
        .req (rr_req),
        .ptr (rr_ptr),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    always_comb begin
        gnt     = rr_gnt;
        win_idx = rr_idx;
        win_any = rr_any;
        ptr_upd = rr_any;
`ifdef WB_ARB_LOAD_PRIO_EN
        // A LOAD grant leaves the pointer alone so the others resume where they were.
        if (req_valid_i[LD]) begin
            gnt      = '0;
            gnt[LD]  = 1'b1;
            win_idx  = W_IDX'(LD);
            win_any  = 1'b1;
            ptr_upd  = 1'b0;
        end
`endif
        // Nothing is granted during reset; requesters keep valid and retry afterwards.
        if (rst) begin
            gnt     = '0;
            win_any = 1'b0;
            ptr_upd = 1'b0;
        end
    end

    assign req_ready_o = gnt;
    assign busy_o      = ~rst & (|(req_valid_i & ~gnt));
    assign ptr_nxt     = (win_idx == W_IDX'(N_REQ - 1)) ? '0 : win_idx + W_IDX'(1);

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr_i[i*W_REG +: W_REG];
                sel_data = req_data_i[i*W_DATA +: W_DATA];
            end
        end
    end

    // Address/data hold their last value on idle cycles; only wb_o drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_o      <= 1'b0;
            wb_r_o    <= '0;
            wb_data_o <= '0;
            rr_ptr    <= '0;
        end else begin
            wb_o <= win_any;
            if (win_any) begin
                wb_r_o    <= sel_addr;
                wb_data_o <= sel_data;
            end
            if (ptr_upd) begin
                rr_ptr <= ptr_nxt;
            end
        end
    end

endmodule
